// File: rtl/updown_load_counter_pkg.sv
// Shared constants for the up/down loadable counter: load-source select
// codes and count-direction codes.
package updown_load_counter_pkg;

  localparam logic LD_SRC_A = 1'b0;
  localparam logic LD_SRC_B = 1'b1;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/updown_src_mux.sv
// Two-input WIDTH-bit selector: out_o = sel_i ? in1_i : in0_i.
// The top module uses one of these for the load source and one for the bypass path.
module updown_src_mux #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in0_i,
  input  logic [WIDTH-1:0] in1_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] out_o
);

  // Plain combinational select.
  always_comb begin
    out_o = in0_i;
    if (sel_i) out_o = in1_i;
  end

endmodule

// File: rtl/updown_load_counter.sv
// Up/down counter with a two-source synchronous load, a registered bypass
// mux output, a combinational terminal-count flag and a registered wrap pulse.
// Optional build macro UPDOWN_LOAD_COUNTER_SATURATE_EN: the counter holds at
// all-ones / zero instead of wrapping (wrap_p still pulses on each attempt).
module updown_load_counter
  import updown_load_counter_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mux_sel,
  input  logic             load_en,
  input  logic             load_sel,
  input  logic             cnt_en,
  input  logic             up,
  output logic [WIDTH-1:0] byp_q,
  output logic [WIDTH-1:0] cnt_q,
  output logic             tc,
  output logic             wrap_p
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q_r, cnt_d;
  logic [WIDTH-1:0] byp_q_r, byp_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] load_val;
  logic             dir_up;

  // Modulo-2^WIDTH single step in the requested direction.
  function automatic logic [WIDTH-1:0] count_step(input logic [WIDTH-1:0] cur,
                                                  input logic             inc);
    return inc ? (cur + ONE) : (cur - ONE);
  endfunction

  // Load source: LD_SRC_A picks src_a, LD_SRC_B picks src_b.
  updown_src_mux #(.WIDTH(WIDTH)) u_load_mux (
    .in0_i (src_a),
    .in1_i (src_b),
    .sel_i (load_sel == LD_SRC_B),
    .out_o (load_val)
  );

  // Bypass path has the opposite polarity: mux_sel=1 picks src_a.
  updown_src_mux #(.WIDTH(WIDTH)) u_byp_mux (
    .in0_i (src_b),
    .in1_i (src_a),
    .sel_i (mux_sel),
    .out_o (byp_d)
  );

  assign dir_up = (up == DIR_UP);

  // Terminal count: about to step past all-ones (up) or zero (down); a load masks it.
  always_comb begin
    tc = cnt_en & ~load_en &
         ((dir_up & (cnt_q_r == ALL_ONES)) | (~dir_up & (cnt_q_r == '0)));
  end

  // Next-state: load beats count beats hold; the wrap pulse mirrors tc one cycle later.
  always_comb begin
    cnt_d  = cnt_q_r;
    wrap_d = tc;
    if (load_en) begin
      cnt_d = load_val;
    end else if (cnt_en) begin
`ifdef UPDOWN_LOAD_COUNTER_SATURATE_EN
      if (!tc) cnt_d = count_step(cnt_q_r, dir_up);
`else
      cnt_d = count_step(cnt_q_r, dir_up);
`endif
    end
  end

  // State registers; asynchronous reset clears pending work immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q_r <= RST_VAL;
      byp_q_r <= '0;
      wrap_q  <= 1'b0;
    end else begin
      cnt_q_r <= cnt_d;
      byp_q_r <= byp_d;
      wrap_q  <= wrap_d;
    end
  end

  assign cnt_q  = cnt_q_r;
  assign byp_q  = byp_q_r;
  assign wrap_p = wrap_q;

endmodule
